// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Bundle between the multicycle control FSM and the MIPS datapath/memory.
//   master : control FSM (consumes IR fields, Zero, MemReady; drives controls)
//   slave  : datapath side (drives IR fields, Zero, MemReady; consumes controls)
//   Signals:
//     Opcode/Funct   IR[31:26] / IR[5:0]
//     Zero           ALU zero flag (beq)
//     MemReady       shared memory completes the current access this cycle
//     PcWrite..PcSource  datapath steering, see controller header
//     AluCtrl        000 and, 001 or, 010 add, 110 sub, 111 slt
//     IllegalInstr   one-cycle pulse on unsupported opcode/funct
//     State          current FSM state, debug only
interface mips_multicycle_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PcWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IrWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       ZeroExt;
  logic [1:0] PcSource;
  logic [2:0] AluCtrl;
  logic       IllegalInstr;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PcWrite, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg,
           RegWrite, AluSrcA, AluSrcB, ZeroExt, PcSource, AluCtrl,
           IllegalInstr, State
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PcWrite, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg,
           RegWrite, AluSrcA, AluSrcB, ZeroExt, PcSource, AluCtrl,
           IllegalInstr, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle MIPS control FSM: FETCH -> DECODE -> EX -> MEM -> WB, with
//   MemReady wait states on the shared instruction/data memory.
//   Ports:
//     Clk    rising-edge clock
//     Rst_n  asynchronous active-low reset; also forces every output to 0
//     bus    mips_multicycle_ctrl_if.master (IR fields, Zero, MemReady in;
//            datapath controls, IllegalInstr, State out)
//   Build option:
//     IMM_OPS_EN  adds addi/andi/ori/slti through IMM_EX -> IMM_WB; when
//                 undefined those opcodes decode as illegal, ZeroExt is 0.
module mips_multicycle_ctrl (
  input  logic Clk,
  input  logic Rst_n,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010;
`ifdef IMM_OPS_EN
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
`endif

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPE_EX = 4'd6, S_RTYPE_WB = 4'd7,
    S_BEQ = 4'd8, S_JUMP = 4'd9
`ifdef IMM_OPS_EN
    , S_IMM_EX = 4'd10, S_IMM_WB = 4'd11
`endif
  } state_t;

  state_t st, nx;

  logic       pcW, iord, mrd, mwr, irw, rdst, m2r, rw, sa, zx, ill;
  logic [1:0] sb, psrc;
  logic [2:0] ac;

  // R-type function decode
  logic       fnOk;
  logic [2:0] fnAc;
  always_comb begin
    fnOk = 1'b1;
    fnAc = 3'b000;
    case (bus.Funct)
      6'b100000: fnAc = 3'b010;
      6'b100010: fnAc = 3'b110;
      6'b100100: fnAc = 3'b000;
      6'b100101: fnAc = 3'b001;
      6'b101010: fnAc = 3'b111;
      default:   fnOk = 1'b0;
    endcase
  end

`ifdef IMM_OPS_EN
  // Immediate group decode; the IR is stable through IMM_EX and IMM_WB, so
  // decoding straight from Opcode holds AluCtrl/ZeroExt across both states.
  logic [2:0] immAc;
  logic       immZx;
  always_comb begin
    immAc = 3'b010;
    immZx = 1'b0;
    case (bus.Opcode)
      OP_ANDI: begin immAc = 3'b000; immZx = 1'b1; end
      OP_ORI:  begin immAc = 3'b001; immZx = 1'b1; end
      OP_SLTI: immAc = 3'b111;
      default: immAc = 3'b010;
    endcase
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) st <= S_FETCH;
    else        st <= nx;

  always_comb begin
    nx = st;
    pcW = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
    rdst = 1'b0; m2r = 1'b0; rw = 1'b0; sa = 1'b0; zx = 1'b0; ill = 1'b0;
    sb = 2'b00; psrc = 2'b00; ac = 3'b000;
    case (st)
      S_FETCH: begin
        mrd = 1'b1; sb = 2'b01; ac = 3'b010;
        if (bus.MemReady) begin irw = 1'b1; pcW = 1'b1; nx = S_DECODE; end
      end
      S_DECODE: begin
        sb = 2'b11; ac = 3'b010;
        case (bus.Opcode)
          OP_LW, OP_SW: nx = S_MEMADR;
          OP_R:         nx = S_RTYPE_EX;
          OP_BEQ:       nx = S_BEQ;
          OP_J:         nx = S_JUMP;
`ifdef IMM_OPS_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nx = S_IMM_EX;
`endif
          default: begin ill = 1'b1; nx = S_FETCH; end
        endcase
      end
      S_MEMADR: begin
        sa = 1'b1; sb = 2'b10; ac = 3'b010;
        nx = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mrd = 1'b1; iord = 1'b1;
        if (bus.MemReady) nx = S_MEMWB;
      end
      S_MEMWB: begin rw = 1'b1; m2r = 1'b1; nx = S_FETCH; end
      S_MEMWR: begin
        mwr = 1'b1; iord = 1'b1;
        if (bus.MemReady) nx = S_FETCH;
      end
      S_RTYPE_EX: begin
        sa = 1'b1;
        // unknown funct: PC already advanced, skip without writeback
        if (fnOk) begin ac = fnAc; nx = S_RTYPE_WB; end
        else      begin ill = 1'b1; nx = S_FETCH; end
      end
      S_RTYPE_WB: begin rw = 1'b1; rdst = 1'b1; nx = S_FETCH; end
      S_BEQ: begin
        sa = 1'b1; ac = 3'b110; psrc = 2'b01; pcW = bus.Zero; nx = S_FETCH;
      end
      S_JUMP: begin psrc = 2'b10; pcW = 1'b1; nx = S_FETCH; end
`ifdef IMM_OPS_EN
      S_IMM_EX: begin
        sa = 1'b1; sb = 2'b10; ac = immAc; zx = immZx; nx = S_IMM_WB;
      end
      S_IMM_WB: begin rw = 1'b1; ac = immAc; zx = immZx; nx = S_FETCH; end
`endif
      default: nx = S_FETCH;
    endcase
  end

  // reset gates every control so nothing reaches memory or the regfile
  assign bus.PcWrite      = Rst_n & pcW;
  assign bus.IorD         = Rst_n & iord;
  assign bus.MemRead      = Rst_n & mrd;
  assign bus.MemWrite     = Rst_n & mwr;
  assign bus.IrWrite      = Rst_n & irw;
  assign bus.RegDst       = Rst_n & rdst;
  assign bus.MemToReg     = Rst_n & m2r;
  assign bus.RegWrite     = Rst_n & rw;
  assign bus.AluSrcA      = Rst_n & sa;
  assign bus.AluSrcB      = Rst_n ? sb : 2'b00;
  assign bus.ZeroExt      = Rst_n & zx;
  assign bus.PcSource     = Rst_n ? psrc : 2'b00;
  assign bus.AluCtrl      = Rst_n ? ac : 3'b000;
  assign bus.IllegalInstr = Rst_n & ill;
  assign bus.State        = st;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed + random instruction stream. A reference model expands each
//   instruction into the per-cycle control pattern it should produce, and
//   every cycle's outputs are compared against it.
module tb_mips_multicycle_ctrl;
  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  typedef struct packed {
    logic       PcWrite, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg,
                RegWrite, AluSrcA;
    logic [1:0] AluSrcB;
    logic       ZeroExt;
    logic [1:0] PcSource;
    logic [2:0] AluCtrl;
    logic       Illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    mr;   // MemReady to drive
    bit    dc;   // MemReady ignored in this cycle: drive random
    string tag;
  } step_t;

  step_t q[$];
  int nTests = 0, nFail = 0;

  function automatic outs_t obsv();
    outs_t o;
    o.PcWrite = bus.PcWrite; o.IorD = bus.IorD; o.MemRead = bus.MemRead;
    o.MemWrite = bus.MemWrite; o.IrWrite = bus.IrWrite; o.RegDst = bus.RegDst;
    o.MemToReg = bus.MemToReg; o.RegWrite = bus.RegWrite; o.AluSrcA = bus.AluSrcA;
    o.AluSrcB = bus.AluSrcB; o.ZeroExt = bus.ZeroExt; o.PcSource = bus.PcSource;
    o.AluCtrl = bus.AluCtrl; o.Illegal = bus.IllegalInstr;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t got;
    got = obsv();
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // expected control pattern of one instruction, cycle by cycle
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, input string nm);
    outs_t o;
    bit legal, fnOk, isImm;
    logic [2:0] fnAc, immAc;
    bit immZx;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.MemRead = 1; o.AluSrcB = 2'b01; o.AluCtrl = 3'b010;
      if (i == fw) begin o.IrWrite = 1; o.PcWrite = 1; end
      q.push_back('{o, (i == fw), 1'b0, {nm, ".fetch"}});
    end
    isImm = 0; immAc = 3'b010; immZx = 0;
`ifdef IMM_OPS_EN
    case (op)
      6'b001000: begin isImm = 1; immAc = 3'b010; end
      6'b001100: begin isImm = 1; immAc = 3'b000; immZx = 1; end
      6'b001101: begin isImm = 1; immAc = 3'b001; immZx = 1; end
      6'b001010: begin isImm = 1; immAc = 3'b111; end
      default: ;
    endcase
`endif
    legal = isImm || op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010};
    o = '0; o.AluSrcB = 2'b11; o.AluCtrl = 3'b010; o.Illegal = !legal;
    q.push_back('{o, 1'b0, 1'b1, {nm, ".decode"}});
    if (!legal) return;
    if (op == 6'b100011 || op == 6'b101011) begin
      o = '0; o.AluSrcA = 1; o.AluSrcB = 2'b10; o.AluCtrl = 3'b010;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".memadr"}});
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.IorD = 1;
        if (op == 6'b100011) o.MemRead = 1; else o.MemWrite = 1;
        q.push_back('{o, (i == mw), 1'b0, {nm, ".mem"}});
      end
      if (op == 6'b100011) begin
        o = '0; o.RegWrite = 1; o.MemToReg = 1;
        q.push_back('{o, 1'b0, 1'b1, {nm, ".memwb"}});
      end
    end else if (op == 6'b000000) begin
      fnOk = 1; fnAc = 3'b000;
      case (fn)
        6'b100000: fnAc = 3'b010;
        6'b100010: fnAc = 3'b110;
        6'b100100: fnAc = 3'b000;
        6'b100101: fnAc = 3'b001;
        6'b101010: fnAc = 3'b111;
        default:   fnOk = 0;
      endcase
      o = '0; o.AluSrcA = 1; o.AluCtrl = fnAc; o.Illegal = !fnOk;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".rex"}});
      if (fnOk) begin
        o = '0; o.RegWrite = 1; o.RegDst = 1;
        q.push_back('{o, 1'b0, 1'b1, {nm, ".rwb"}});
      end
    end else if (op == 6'b000100) begin
      o = '0; o.AluSrcA = 1; o.AluCtrl = 3'b110; o.PcSource = 2'b01; o.PcWrite = z;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".beq"}});
    end else if (op == 6'b000010) begin
      o = '0; o.PcSource = 2'b10; o.PcWrite = 1;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".j"}});
    end else begin
      o = '0; o.AluSrcA = 1; o.AluSrcB = 2'b10; o.AluCtrl = immAc; o.ZeroExt = immZx;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".iex"}});
      o = '0; o.RegWrite = 1; o.AluCtrl = immAc; o.ZeroExt = immZx;
      q.push_back('{o, 1'b0, 1'b1, {nm, ".iwb"}});
    end
  endtask

  task automatic runStep(input step_t s, input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
    @(negedge Clk);
    bus.Opcode = op; bus.Funct = fn; bus.Zero = z;
    bus.MemReady = s.dc ? 1'($urandom_range(0, 1)) : s.mr;
    #1 check(s.tag, s.o);
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw, input string nm);
    model(op, fn, z, fw, mw, nm);
    foreach (q[i]) runStep(q[i], op, fn, z);
  endtask

  function automatic logic [5:0] randFunct();
    logic [5:0] t [5];
    t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return t[$urandom_range(0, 4)];
  endfunction

  initial begin
    outs_t o;
    logic [5:0] op, fn, imms [4];
    string nm;
    imms = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};

    // reset: everything 0 even with MemReady high
    Rst_n = 1'b0; bus.MemReady = 1'b1; bus.Opcode = 6'b100011;
    bus.Funct = 6'b0; bus.Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1 check("reset", '0);
    end
    @(negedge Clk);
    Rst_n = 1'b1; bus.MemReady = 1'b0;
    #1;
    o = '0; o.MemRead = 1; o.AluSrcB = 2'b01; o.AluCtrl = 3'b010;
    check("release", o);

    // directed sequence
    runInstr(6'b100011, 6'b000000, 1'b0, 0, 0, "lw");
    runInstr(6'b000000, 6'b100010, 1'b0, 0, 0, "sub");
    runInstr(6'b000000, 6'b000111, 1'b0, 0, 0, "badfn");
    runInstr(6'b000100, 6'b000000, 1'b1, 0, 0, "beqT");
    runInstr(6'b000100, 6'b000000, 1'b0, 0, 0, "beqN");
    runInstr(6'b101011, 6'b000000, 1'b0, 0, 2, "swWait");
    runInstr(6'b001101, 6'b000000, 1'b0, 0, 0, "ori");
    runInstr(6'b000010, 6'b000000, 1'b0, 1, 0, "j");
    runInstr(6'b111111, 6'b000000, 1'b0, 2, 0, "badop");

    // abort an lw mid-read: outputs must drop in the same cycle
    model(6'b100011, 6'b0, 1'b0, 0, 1, "abort");
    for (int i = 0; i < 4; i++) runStep(q[i], 6'b100011, 6'b0, 1'b0);
    #2 Rst_n = 1'b0;
    #1 check("abort.rst", '0);
    @(negedge Clk);
    Rst_n = 1'b1; bus.MemReady = 1'b0;
    #1;
    o = '0; o.MemRead = 1; o.AluSrcB = 2'b01; o.AluCtrl = 3'b010;
    check("abort.fetch", o);

    // random instruction stream
    for (int n = 0; n < 200; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 7))
        0: begin op = 6'b100011; nm = "rlw"; end
        1: begin op = 6'b101011; nm = "rsw"; end
        2: begin op = 6'b000000; fn = randFunct(); nm = "rr"; end
        3: begin op = 6'b000000; nm = "rrfn"; end
        4: begin op = 6'b000100; nm = "rbeq"; end
        5: begin op = 6'b000010; nm = "rj"; end
        6: begin op = imms[$urandom_range(0, 3)]; nm = "rimm"; end
        default: begin op = 6'($urandom); nm = "rop"; end
      endcase
      runInstr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
               $urandom_range(0, 2), nm);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath. It decodes Opcode/Funct from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states. On every cycle it drives the ALU's AluCtrl[2:0] and operand-select lines, consumes the ALU Zero flag for beq, and handshakes with a single shared instruction/data memory through MemReady wait states.

## Interface
Parameters:
- none; the instruction set is fixed except for the optional immediate group (see Configuration).

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous reset, active low
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU Zero flag
- MemReady  in  1  memory completes the current read/write this cycle
- PcWrite  out  1  load PC
- IorD  out  1  memory address source: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IrWrite  out  1  load IR and MDR
- RegDst  out  1  write register: 0=rt, 1=rd
- MemToReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- AluSrcA  out  1  0=PC, 1=rs
- AluSrcB  out  2  00=rt, 01=4, 10=sext(imm), 11=sext(imm)<<2
- ZeroExt  out  1  imm extension is zero-extend (andi/ori)
- PcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- AluCtrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- IllegalInstr  out  1  one-cycle pulse: unsupported opcode/funct
- State  out  4  current state encoding, for debug/verification

## Operation
- Outputs are a Moore decode of State. The only exceptions are PcWrite and IrWrite in FETCH, which are gated by MemReady, and PcWrite in BEQ, which equals Zero.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluCtrl=010, PcSource=00. Hold while MemReady=0. When MemReady=1: IrWrite=1, PcWrite=1, go to DECODE.
- DECODE: AluSrcA=0, AluSrcB=11, AluCtrl=010 (branch target). Next state by opcode:
  - lw (100011) / sw (101011) -> MEMADR
  - R-type (000000) -> RTYPE_EX
  - beq (000100) -> BEQ
  - j (000010) -> JUMP
  - immediate group (when compiled in) -> IMM_EX
  - anything else -> FETCH with IllegalInstr=1
- MEMADR: AluSrcA=1, AluSrcB=10, AluCtrl=010. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1; hold until MemReady, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until MemReady, then FETCH.
- RTYPE_EX: AluSrcA=1, AluSrcB=00, AluCtrl from Funct:
  - add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111
  - other Funct -> FETCH with IllegalInstr=1, no writeback
  - otherwise -> RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
- BEQ: AluSrcA=1, AluSrcB=00, AluCtrl=110, PcSource=01, PcWrite=Zero -> FETCH.
- JUMP: PcSource=10, PcWrite=1 -> FETCH.
- Illegal instructions are skipped: PC has already advanced by 4 and no architectural state changes.
- Unused State encodings recover to FETCH on the next edge.

## Timing
- Rst_n low: State=FETCH immediately (async). All outputs 0, including MemRead, because outputs are gated by Rst_n. After release, FETCH outputs appear combinationally.
- Reset asserted mid-instruction aborts it at once. Any in-progress memory request drops in the same cycle.
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, imm 4, beq 3, j 3, illegal 2.
- Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle. MemRead/MemWrite, IorD and address selects stay stable throughout the wait.
- MemReady is ignored in every other state.

## Configuration
- IMM_OPS_EN defined: decode addi 001000, andi 001100, ori 001101, slti 001010 through IMM_EX -> IMM_WB.
  - IMM_EX: AluSrcA=1, AluSrcB=10, AluCtrl 010/000/001/111 respectively. ZeroExt=1 for andi/ori only.
  - IMM_WB: RegWrite=1, RegDst=0, MemToReg=0; ZeroExt/AluCtrl held from IMM_EX.
- IMM_OPS_EN undefined: those opcodes are illegal (IllegalInstr pulse in DECODE). IMM_EX/IMM_WB are absent and ZeroExt is tied 0.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with MemReady=1 -> all outputs 0, State=FETCH. Release -> MemRead=1, AluCtrl=010, AluSrcB=01.
- lw with MemReady=1 always -> state path FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. RegWrite=1 with MemToReg=1 in cycle 5 only.
- R-type sub (Funct 100010), then Funct 000111 -> first: AluCtrl=110 in RTYPE_EX, RegWrite/RegDst=1 next cycle. Second: IllegalInstr 1-cycle pulse, RegWrite never asserted.
- beq with Zero=1, then Zero=0 -> PcWrite=1/PcSource=01 in the BEQ cycle for the first. PcWrite=0 for the second. Both take 3 cycles.
- sw with MemReady low for 2 cycles in MEMWR -> MemWrite=1, IorD=1 held for 3 cycles, then FETCH. Total 6 cycles.
- ori (001101) -> with IMM_OPS_EN: AluCtrl=001, ZeroExt=1, RegWrite=1 in cycle 4. Without it: IllegalInstr pulse in DECODE, back in FETCH in cycle 3.
